coef_limit_mc: RTL and testbench
================================

COEF_LIMIT_MC -- requirements
Module: coef_limit_mc

Interface
REQ-001 Parameter WIDTH, default 16, coefficient width (two's complement; 1.0 = 2^(WIDTH-2)); legal range 12..24.
REQ-002 Parameter CHANNELS, default 4, number of time-multiplexed ADPCM channels; CHW = max(1, clog2(CHANNELS)).
REQ-003 Parameter CNTW, default 8, per-channel clip-counter width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  A1T/A2T/in_ch qualify this cycle; no backpressure.
REQ-007 in_ch  input  CHW  channel of current sample.
REQ-008 A1T, A2T  input  WIDTH each  unlimited a1/a2 predictor coefficients.
REQ-009 bypass  input  1  1 = pass A1T/A2T unlimited (coefficients still pipelined).
REQ-010 clr_cnt  input  1  synchronous clear of all clip counters.
REQ-011 rd_ch  input  CHW  clip-counter readback select.
REQ-012 out_valid  output  1; out_ch  output  CHW; A1P, A2P  output  WIDTH each  limited coefficients.
REQ-013 rd_cnt  output  CNTW  registered clip count of rd_ch.
REQ-014 scan_in0..4, scan_enable, test_mode  input  1 each; scan_out0..4  output  1 each; scan_out* tied low in RTL, connected by scan insertion.

Function
REQ-015 Fixed 2-cycle latency: sample accepted in cycle N appears on outputs in cycle N+2 with out_valid=1; one sample per cycle throughput.
REQ-016 Stage 1 SHALL register A2P1 = clamp(A2T, A2LL, A2UL), A2UL = 3*2^(WIDTH-4) (0x3000 @16), A2LL = -A2UL (0xD000 @16), plus A1T, channel, valid, bypass, a2-clip flag.
REQ-017 Stage 2 SHALL compute A1UL = OME - A2P1, OME = 15*2^(WIDTH-6) (0x3C00 @16), A1LL = -A1UL, and register A1P = clamp(A1T, A1LL, A1UL), A2P = A2P1.
REQ-018 Clamp bounds inclusive: a value equal to a bound passes unchanged and is not a clip.
REQ-019 Intermediate A1UL arithmetic SHALL use WIDTH+1 bits; no overflow for any input.
REQ-020 bypass=1 at acceptance: A1P=A1T, A2P=A2T after 2 cycles, clip flags forced 0.
REQ-021 in_ch >= CHANNELS with in_valid=1: sample dropped (no out_valid, no counter change).
REQ-022 in_valid=0: stage registers hold coefficient data; only valid bit propagates 0; A1P/A2P hold last value.
REQ-023 Clip counter of out_ch SHALL increment by 1 in the cycle out_valid=1 and (a1 clip or a2 clip); saturates at 2^CNTW-1, never wraps.
REQ-024 clr_cnt=1 clears all counters; clear wins over simultaneous increment.
REQ-025 rd_cnt = counter[rd_ch] registered one cycle after rd_ch; reflects counter value before same-cycle update; rd_ch >= CHANNELS returns 0.

Reset
REQ-026 reset low SHALL asynchronously clear: out_valid=0, out_ch=0, A1P=0, A2P=0, rd_cnt=0, all pipeline valids, all counters.
REQ-027 Samples in flight at reset assertion are discarded; first out_valid after release is exactly 2 cycles after the first accepted sample.
REQ-028 Reset release is synchronised by the integrating top; block assumes release clean to clk.

Structure
REQ-029 Shared package holds WIDTH-derived constants A2UL, OME, CHW function, and default parameter values, reused by future LIMD-class blocks.
REQ-030 One sub-module natural: coef_clamp (signed inclusive clamp, value/upper bound in, limited value + clip flag out), instantiated in both stages.
REQ-031 Counters stored as a CHANNELS x CNTW register array; no memory macros.

Verification
REQ-032 WIDTH=16, ch1: A2T=0x4000, A1T=0x0000 -> 2 cycles later A2P=0x3000, A1P=0x0000, out_ch=1, counter[1]=1.
REQ-033 A2T=0x0000, A1T=0x7000 -> A1P=0x3C00; A2T=0xC000, A1T=0x8000 -> A2P=0xD000, A1P=0x9400 (A1UL=0x6C00).
REQ-034 A2T=0x3000, A1T=0x0C00 (both on bounds) -> outputs unchanged, no counter increment; bypass=1 with A2T=0x7FFF -> A2P=0x7FFF, no increment.
REQ-035 Back-to-back clips on ch2 for 300 cycles, CNTW=8 -> rd_cnt(ch2)=0xFF; clr_cnt asserted during increment -> rd_cnt=0 next read.
REQ-036 Reset pulsed low with two samples in flight -> out_valid never rises for them; all outputs 0 during reset; in_ch=CHANNELS sample -> no out_valid.
REQ-037 Random regression CHANNELS=8, WIDTH=20 vs reference model of REQ-016/017, >=10000 samples, zero mismatches.

Source files
------------

// File: rtl/coef_limit_pkg.sv
// Shared constants and helpers for LIMD-class coefficient limiters.
// All bounds scale with the coefficient width (1.0 = 2^(WIDTH-2)).
package coef_limit_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_CNTW     = 8;

    function automatic int chw_of(input int channels);
        return (channels <= 2) ? 1 : $clog2(channels);
    endfunction

    // a2 upper bound: 0.75
    function automatic int a2_ul_of(input int width);
        return 3 << (width - 4);
    endfunction

    // One-minus-epsilon term used to derive the a1 bound: 15/16
    function automatic int ome_of(input int width);
        return 15 << (width - 6);
    endfunction

endpackage

// File: rtl/coef_limit_mc_clamp.sv
// Signed inclusive clamp to [-upper, upper]; clip is set only when the value
// lies strictly outside the bounds.
module coef_clamp #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] value,
    input  logic signed [W-1:0] upper,
    output logic signed [W-1:0] result,
    output logic                clip
);

    logic signed [W-1:0] lower;

    assign lower = -upper;

    always_comb begin
        result = value;
        clip   = 1'b0;
        if (value > upper) begin
            result = upper;
            clip   = 1'b1;
        end else if (value < lower) begin
            result = lower;
            clip   = 1'b1;
        end
    end

endmodule

// File: rtl/coef_limit_mc.sv
// Two-stage, channel-multiplexed a1/a2 predictor coefficient limiter with
// per-channel saturating clip counters and registered counter readback.
module coef_limit_mc
    import coef_limit_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int CHANNELS = DEF_CHANNELS,
    parameter  int CNTW     = DEF_CNTW,
    localparam int CHW      = chw_of(CHANNELS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [CHW-1:0]   in_ch,
    input  logic [WIDTH-1:0] A1T,
    input  logic [WIDTH-1:0] A2T,
    input  logic             bypass,
    input  logic             clr_cnt,
    input  logic [CHW-1:0]   rd_ch,
    output logic             out_valid,
    output logic [CHW-1:0]   out_ch,
    output logic [WIDTH-1:0] A1P,
    output logic [WIDTH-1:0] A2P,
    output logic [CNTW-1:0]  rd_cnt,
    input  logic             scan_in0,
    input  logic             scan_in1,
    input  logic             scan_in2,
    input  logic             scan_in3,
    input  logic             scan_in4,
    input  logic             scan_enable,
    input  logic             test_mode,
    output logic             scan_out0,
    output logic             scan_out1,
    output logic             scan_out2,
    output logic             scan_out3,
    output logic             scan_out4
);

    localparam logic signed [WIDTH-1:0] A2UL   = WIDTH'(a2_ul_of(WIDTH));
    localparam logic signed [WIDTH:0]   OME    = (WIDTH+1)'(ome_of(WIDTH));
    localparam logic [CHW:0]            CH_LIM = (CHW+1)'(CHANNELS);

    logic             ch_ok;
    logic [WIDTH-1:0] a2_lim;
    logic             a2_clip;

    logic             s1_valid;
    logic [CHW-1:0]   s1_ch;
    logic [WIDTH-1:0] s1_a1;
    logic [WIDTH-1:0] s1_a2;
    logic             s1_byp;
    logic             s1_a2_clip;

    logic [WIDTH:0]   a1_ul;
    logic [WIDTH:0]   a1_lim_x;
    logic             a1_clip;
    logic             out_clip;

    logic [CNTW-1:0]  cnt [CHANNELS];
    logic             rd_ok;
    logic             unused_bits;

    assign ch_ok = in_valid && ({1'b0, in_ch} < CH_LIM);
    assign rd_ok = {1'b0, rd_ch} < CH_LIM;

    coef_clamp #(.W(WIDTH)) u_a2_clamp (
        .value  (A2T),
        .upper  (A2UL),
        .result (a2_lim),
        .clip   (a2_clip)
    );

    // Coefficient data only loads on an accepted sample, so idle cycles hold it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_ch      <= '0;
            s1_a1      <= '0;
            s1_a2      <= '0;
            s1_byp     <= 1'b0;
            s1_a2_clip <= 1'b0;
        end else begin
            s1_valid <= ch_ok;
            if (ch_ok) begin
                s1_ch      <= in_ch;
                s1_a1      <= A1T;
                s1_a2      <= bypass ? A2T : a2_lim;
                s1_byp     <= bypass;
                s1_a2_clip <= a2_clip && !bypass;
            end
        end
    end

    // One extra bit keeps OME - A2P1 exact for every stage-1 value.
    assign a1_ul = OME - {s1_a2[WIDTH-1], s1_a2};

    coef_clamp #(.W(WIDTH+1)) u_a1_clamp (
        .value  ({s1_a1[WIDTH-1], s1_a1}),
        .upper  (a1_ul),
        .result (a1_lim_x),
        .clip   (a1_clip)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            A1P       <= '0;
            A2P       <= '0;
            out_clip  <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_ch   <= s1_ch;
                A1P      <= s1_byp ? s1_a1 : a1_lim_x[WIDTH-1:0];
                A2P      <= s1_a2;
                out_clip <= !s1_byp && (a1_clip || s1_a2_clip);
            end
        end
    end

    // Clear takes priority over a coincident increment; counts saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else if (clr_cnt) begin
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else if (out_valid && out_clip && (cnt[out_ch] != '1)) begin
            cnt[out_ch] <= cnt[out_ch] + CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt <= '0;
        end else begin
            rd_cnt <= rd_ok ? cnt[rd_ch] : '0;
        end
    end

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

    assign unused_bits = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                           scan_enable, test_mode, a1_lim_x[WIDTH]};

endmodule

// File: tb/tb_coef_limit_mc.sv
// Scoreboard bench for coef_limit_mc (WIDTH=16, CHANNELS=3, CNTW=8) using
// directed vectors with hand-computed limited coefficients and clip counts.
module tb_coef_limit_mc;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_ch;
    logic [15:0] A1T;
    logic [15:0] A2T;
    logic        bypass;
    logic        clr_cnt;
    logic [1:0]  rd_ch;
    logic        out_valid;
    logic [1:0]  out_ch;
    logic [15:0] A1P;
    logic [15:0] A2P;
    logic [7:0]  rd_cnt;
    logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic        scan_enable, test_mode;
    logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] a1;
        logic [15:0] a2;
    } exp_t;

    exp_t exp_q[$];
    int   n_vectors;
    int   n_miscompares;

    coef_limit_mc #(.WIDTH(16), .CHANNELS(3), .CNTW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ch       (in_ch),
        .A1T         (A1T),
        .A2T         (A2T),
        .bypass      (bypass),
        .clr_cnt     (clr_cnt),
        .rd_ch       (rd_ch),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .A1P         (A1P),
        .A2P         (A2P),
        .rd_cnt      (rd_cnt),
        .scan_in0    (scan_in0),
        .scan_in1    (scan_in1),
        .scan_in2    (scan_in2),
        .scan_in3    (scan_in3),
        .scan_in4    (scan_in4),
        .scan_enable (scan_enable),
        .test_mode   (test_mode),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ch, input logic [15:0] a1t,
                                 input logic [15:0] a2t, input logic byp,
                                 input logic [15:0] e_a1, input logic [15:0] e_a2,
                                 input logic expect_out);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1;
        in_ch    = ch;
        A1T      = a1t;
        A2T      = a2t;
        bypass   = byp;
        if (expect_out) begin
            e.ch = ch;
            e.a1 = e_a1;
            e.a2 = e_a2;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            bypass   = 1'b0;
        end
    endtask

    task automatic readCount(input logic [1:0] ch, input logic [7:0] expected);
        @(negedge clk);
        in_valid = 1'b0;
        rd_ch    = ch;
        @(posedge clk);
        #1;
        checkOutput($sformatf("rd_cnt_ch%0d", ch), {24'd0, rd_cnt}, {24'd0, expected});
    endtask

    // Every presented output is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            n_vectors++;
            if (exp_q.size() == 0) begin
                n_miscompares++;
                $display("[TB] FAIL unexpected_out: got ch=%0d A1P=%h A2P=%h, expected no output",
                         out_ch, A1P, A2P);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({out_ch, A1P, A2P} !== {e.ch, e.a1, e.a2}) begin
                    n_miscompares++;
                    $display("[TB] FAIL sample_out: got ch=%0d A1P=%h A2P=%h, expected ch=%0d A1P=%h A2P=%h",
                             out_ch, A1P, A2P, e.ch, e.a1, e.a2);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk = 1'b0;   reset = 1'b0;  in_valid = 1'b0; in_ch = '0;
        A1T = '0;     A2T = '0;      bypass = 1'b0;   clr_cnt = 1'b0; rd_ch = '0;
        scan_in0 = 1'b0; scan_in1 = 1'b0; scan_in2 = 1'b0; scan_in3 = 1'b0;
        scan_in4 = 1'b0; scan_enable = 1'b0; test_mode = 1'b0;
        n_vectors = 0; n_miscompares = 0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_A1P", {16'd0, A1P}, 32'd0);
        checkOutput("rst_A2P", {16'd0, A2P}, 32'd0);
        checkOutput("rst_out_ch", {30'd0, out_ch}, 32'd0);
        checkOutput("rst_rd_cnt", {24'd0, rd_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(2'd1, 16'h0000, 16'h4000, 1'b0, 16'h0000, 16'h3000, 1'b1);
        applyStimulus(2'd0, 16'h7000, 16'h0000, 1'b0, 16'h3C00, 16'h0000, 1'b1);
        applyStimulus(2'd0, 16'h8000, 16'hC000, 1'b0, 16'h9400, 16'hD000, 1'b1);
        applyStimulus(2'd2, 16'h0C00, 16'h3000, 1'b0, 16'h0C00, 16'h3000, 1'b1);
        applyStimulus(2'd2, 16'h1234, 16'h7FFF, 1'b1, 16'h1234, 16'h7FFF, 1'b1);
        applyStimulus(2'd1, 16'hF400, 16'hD000, 1'b0, 16'hF400, 16'hD000, 1'b1);
        applyStimulus(2'd1, 16'hC000, 16'h1000, 1'b0, 16'hD400, 16'h1000, 1'b1);
        applyStimulus(2'd0, 16'h0000, 16'h3001, 1'b0, 16'h0000, 16'h3000, 1'b1);
        applyStimulus(2'd2, 16'h7FFF, 16'h8000, 1'b0, 16'h6C00, 16'hD000, 1'b1);
        applyStimulus(2'd1, 16'h8000, 16'h8000, 1'b1, 16'h8000, 16'h8000, 1'b1);
        applyStimulus(2'd3, 16'h7000, 16'h4000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        idle(4);
        checkOutput("hold_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("hold_A1P", {16'd0, A1P}, 32'h8000);
        checkOutput("hold_A2P", {16'd0, A2P}, 32'h8000);

        readCount(2'd0, 8'd3);
        readCount(2'd1, 8'd2);
        readCount(2'd2, 8'd1);
        readCount(2'd3, 8'd0);

        repeat (300) applyStimulus(2'd2, 16'h0000, 16'h4000, 1'b0, 16'h0000, 16'h3000, 1'b1);
        idle(4);
        readCount(2'd2, 8'hFF);

        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        readCount(2'd2, 8'd0);

        repeat (3) applyStimulus(2'd2, 16'h0000, 16'h4000, 1'b0, 16'h0000, 16'h3000, 1'b1);
        idle(1);
        @(negedge clk); clr_cnt = 1'b1;
        @(negedge clk); clr_cnt = 1'b0;
        idle(2);
        readCount(2'd2, 8'd0);
        readCount(2'd0, 8'd0);

        applyStimulus(2'd1, 16'h0000, 16'h4000, 1'b0, 16'h0000, 16'h3000, 1'b1);
        idle(4);
        readCount(2'd1, 8'd1);

        applyStimulus(2'd0, 16'h0000, 16'h4000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        applyStimulus(2'd1, 16'h7000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("inrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("inrst_A1P", {16'd0, A1P}, 32'd0);
        checkOutput("inrst_A2P", {16'd0, A2P}, 32'd0);
        checkOutput("inrst_out_ch", {30'd0, out_ch}, 32'd0);
        checkOutput("inrst_rd_cnt", {24'd0, rd_cnt}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(4);
        checkOutput("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        readCount(2'd1, 8'd0);

        applyStimulus(2'd2, 16'h0100, 16'hF000, 1'b0, 16'h0100, 16'hF000, 1'b1);
        idle(1);
        checkOutput("latency_cycle1", {31'd0, out_valid}, 32'd0);
        idle(1);
        checkOutput("latency_cycle2", {31'd0, out_valid}, 32'd1);
        idle(4);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
